// File: rtl/contador_bcd_ndigitos_pkg.sv
`default_nettype none
// ============================================================================
// Module      : contador_bcd_ndigitos_pkg
// Description : Shared BCD constants and a digit-clamp helper used by the
//               BCD counter and its per-digit cell.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package contador_bcd_ndigitos_pkg;

  localparam logic [3:0] BCD_ZERO = 4'd0;
  localparam logic [3:0] BCD_MAX  = 4'd9;

  // Any nibble above 9 is read as 9, so downstream logic only ever sees
  // legal BCD digits.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/contador_bcd_ndigitos_digito.sv
`default_nettype none
// ============================================================================
// Module      : digito_bcd
// Description : One BCD digit register with its ripple increment/decrement
//               step. Clear, load and boundary override come from the top.
// Ports       : clock    - system clock
//               rst_i    - synchronous clear (highest priority)
//               ld_i     - load ld_val_i (overrides stepping)
//               ld_val_i - value to load (already sanitised)
//               en_i     - step enable for the whole chain
//               dir_i    - 0 = up, 1 = down
//               cin_i    - carry (up) / borrow (down) from the lower digit
//               value_o  - current digit
//               cout_o   - carry / borrow towards the next digit
// Revision    : 1.0 - initial release
// ============================================================================
module digito_bcd
  import contador_bcd_ndigitos_pkg::*;
(
  input  logic       clock,
  input  logic       rst_i,
  input  logic       ld_i,
  input  logic [3:0] ld_val_i,
  input  logic       en_i,
  input  logic       dir_i,
  input  logic       cin_i,
  output logic [3:0] value_o,
  output logic       cout_o
);

  logic [3:0] value_q;
  logic [3:0] value_d;

  always_comb begin
    value_d = value_q;
    if (dir_i) begin
      value_d = (value_q == BCD_ZERO) ? BCD_MAX : (value_q - 4'd1);
    end else begin
      value_d = (value_q == BCD_MAX) ? BCD_ZERO : (value_q + 4'd1);
    end
  end

  always_ff @(posedge clock) begin
    if (rst_i) begin
      value_q <= BCD_ZERO;
    end else if (ld_i) begin
      value_q <= ld_val_i;
    end else if (en_i && cin_i) begin
      value_q <= value_d;
    end
  end

  // A digit passes the step on only when it rolls over in the current
  // direction and it is itself being stepped.
  assign cout_o  = cin_i & (dir_i ? (value_q == BCD_ZERO) : (value_q == BCD_MAX));
  assign value_o = value_q;

endmodule
`default_nettype wire

// File: rtl/contador_bcd_ndigitos.sv
`default_nettype none
// ============================================================================
// Module      : contador_bcd_ndigitos
// Description : DIGITS-digit synchronous BCD counter with up/down count,
//               parallel load, programmable terminal value, wrap or
//               saturate at the boundaries and a registered overflow pulse.
// Ports       : clock       - system clock
//               zera        - synchronous clear, highest priority
//               conta       - count enable
//               decrementa  - 0 = up, 1 = down
//               carrega     - parallel load of valor_carga
//               valor_carga - BCD load value (digits > 9 read as 9)
//               limite      - BCD terminal value (digits > 9 read as 9)
//               digitos     - registered count
//               fim         - combinational terminal flag
//               transbordo  - registered one-cycle boundary pulse
// Revision    : 1.0 - initial release
// ============================================================================
module contador_bcd_ndigitos
  import contador_bcd_ndigitos_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int WRAP   = 1
) (
  input  logic                  clock,
  input  logic                  zera,
  input  logic                  conta,
  input  logic                  decrementa,
  input  logic                  carrega,
  input  logic [4*DIGITS-1:0]   valor_carga,
  input  logic [4*DIGITS-1:0]   limite,
  output logic [4*DIGITS-1:0]   digitos,
  output logic                  fim,
  output logic                  transbordo
);

  localparam int   c_W    = 4 * DIGITS;
  localparam logic c_WRAP = (WRAP != 0);

  logic [c_W-1:0] w_lim_s;
  logic [c_W-1:0] w_carga_s;
  logic [c_W-1:0] w_ld_val;
  logic [DIGITS:0] w_carry;
  logic           w_step;
  logic           w_at_top;
  logic           w_at_zero;
  logic           w_bnd;
  logic           w_ld;
  logic           w_en;
  logic           w_unused_carry;
  logic           transbordo_q;
  logic           transbordo_d;

  always_comb begin
    w_lim_s   = '0;
    w_carga_s = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_lim_s[4*i +: 4]   = bcd_clamp(limite[4*i +: 4]);
      w_carga_s[4*i +: 4] = bcd_clamp(valor_carga[4*i +: 4]);
    end
  end

  // With every digit a legal BCD value, an unsigned compare of the packed
  // vectors is exactly a most-significant-digit-first magnitude compare.
  assign w_at_top  = (digitos >= w_lim_s);
  assign w_at_zero = (digitos == '0);

  assign w_step = conta & ~carrega;
  assign w_bnd  = w_step & (decrementa ? w_at_zero : w_at_top);
  // At a boundary the chain never steps: wrap is a load, saturate a hold.
  assign w_en   = w_step & ~w_bnd;
  assign w_ld   = carrega | (w_bnd & c_WRAP);

  always_comb begin
    w_ld_val = '0;
    if (carrega) begin
      w_ld_val = w_carga_s;
    end else if (decrementa) begin
      w_ld_val = w_lim_s;
    end
  end

  assign w_carry[0] = 1'b1;

  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      digito_bcd u_digito (
        .clock    (clock),
        .rst_i    (zera),
        .ld_i     (w_ld),
        .ld_val_i (w_ld_val[4*g +: 4]),
        .en_i     (w_en),
        .dir_i    (decrementa),
        .cin_i    (w_carry[g]),
        .value_o  (digitos[4*g +: 4]),
        .cout_o   (w_carry[g+1])
      );
    end
  endgenerate

  // Carry out of the top digit is not needed: boundaries are decided by
  // the limite / zero compares above.
  assign w_unused_carry = w_carry[DIGITS];

  assign transbordo_d = w_bnd;

  always_ff @(posedge clock) begin
    if (zera) begin
      transbordo_q <= 1'b0;
    end else begin
      transbordo_q <= transbordo_d;
    end
  end

  assign transbordo = transbordo_q;
  assign fim        = decrementa ? w_at_zero : (digitos == w_lim_s);

endmodule
`default_nettype wire

// File: tb/tb_contador_bcd_ndigitos.sv
`default_nettype none
// ============================================================================
// Module      : tb_contador_bcd_ndigitos
// Description : Self-checking bench for contador_bcd_ndigitos (DIGITS=3).
//               One wrapping and one saturating instance share stimulus and
//               are compared every cycle against an integer-arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_contador_bcd_ndigitos;

  localparam int c_D = 3;
  localparam int c_W = 4 * c_D;

  logic           clock = 1'b0;
  logic           zera = 1'b0, conta = 1'b0, decrementa = 1'b0, carrega = 1'b0;
  logic [c_W-1:0] valor_carga = '0, limite = '0;
  logic [c_W-1:0] dig_w, dig_s;
  logic           fim_w, fim_s, tr_w, tr_s;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  contador_bcd_ndigitos #(.DIGITS(c_D), .WRAP(1)) dut_w (
    .clock(clock), .zera(zera), .conta(conta), .decrementa(decrementa),
    .carrega(carrega), .valor_carga(valor_carga), .limite(limite),
    .digitos(dig_w), .fim(fim_w), .transbordo(tr_w));

  contador_bcd_ndigitos #(.DIGITS(c_D), .WRAP(0)) dut_s (
    .clock(clock), .zera(zera), .conta(conta), .decrementa(decrementa),
    .carrega(carrega), .valor_carga(valor_carga), .limite(limite),
    .digitos(dig_s), .fim(fim_s), .transbordo(tr_s));

  // ---------------- reference model (plain integers) ----------------
  function automatic int to_int(input logic [c_W-1:0] x);
    int v = 0;
    int m = 1;
    for (int i = 0; i < c_D; i++) begin
      int d = int'(x[4*i +: 4]);
      if (d > 9) d = 9;
      v += d * m;
      m *= 10;
    end
    return v;
  endfunction

  function automatic logic [c_W-1:0] to_bcd(input int v);
    logic [c_W-1:0] r = '0;
    int t = v;
    for (int i = 0; i < c_D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int nxt(input int v, input bit wrap, input bit z, input bit ld,
                             input bit c, input bit d, input int lv, input int lim,
                             output bit t);
    t = 1'b0;
    if (z) return 0;
    if (ld) return lv;
    if (!c) return v;
    if (!d) begin
      if (v >= lim) begin t = 1'b1; return wrap ? 0 : v; end
      return v + 1;
    end
    if (v == 0) begin t = 1'b1; return wrap ? lim : 0; end
    return v - 1;
  endfunction

  int mw = 0, ms = 0;
  bit tw = 1'b0, ts = 1'b0;
  bit valid = 1'b0;

  always @(posedge clock) begin
    bit t1, t2;
    int n1, n2;
    n1 = nxt(mw, 1'b1, zera, carrega, conta, decrementa, to_int(valor_carga), to_int(limite), t1);
    n2 = nxt(ms, 1'b0, zera, carrega, conta, decrementa, to_int(valor_carga), to_int(limite), t2);
    mw <= n1; ms <= n2; tw <= t1; ts <= t2;
    if (zera) valid <= 1'b1;
  end

  task automatic chk(input string name, input logic [c_W-1:0] act, input logic [c_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare, mid-cycle, against the model.
  always @(negedge clock) begin
    if (valid) begin
      int lim;
      lim = to_int(limite);
      chk("model digitos W", dig_w, to_bcd(mw));
      chk("model digitos S", dig_s, to_bcd(ms));
      chk("model transbordo W", c_W'(tr_w), c_W'(tw));
      chk("model transbordo S", c_W'(tr_s), c_W'(ts));
      chk("model fim W", c_W'(fim_w), c_W'(decrementa ? (mw == 0) : (mw == lim)));
      chk("model fim S", c_W'(fim_s), c_W'(decrementa ? (ms == 0) : (ms == lim)));
    end
  end

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cyc(input bit z, input bit ld, input bit c, input bit d,
                     input logic [c_W-1:0] v, input logic [c_W-1:0] l);
    zera = z; carrega = ld; conta = c; decrementa = d;
    valor_carga = v; limite = l;
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset and basic up-count
    cyc(1, 0, 0, 0, 12'h000, 12'h999);
    chk("reset digitos", dig_w, 12'h000);
    chk("reset transbordo", c_W'(tr_w), '0);
    for (int i = 1; i <= 12; i++) begin
      cyc(0, 0, 1, 0, 12'h000, 12'h999);
      if (i == 9)  chk("count 009", dig_w, 12'h009);
      if (i == 10) chk("ripple 010", dig_w, 12'h010);
    end
    chk("count 012", dig_w, 12'h012);
    chk("count no transbordo", c_W'(tr_w), '0);

    // Full-range wrap
    cyc(0, 1, 0, 0, 12'h998, 12'h999);
    cyc(0, 0, 1, 0, 12'h000, 12'h999);
    chk("wrap 999", dig_w, 12'h999);
    chk("wrap fim", c_W'(fim_w), c_W'(1));
    cyc(0, 0, 1, 0, 12'h000, 12'h999);
    chk("wrap 000", dig_w, 12'h000);
    chk("wrap pulse", c_W'(tr_w), c_W'(1));
    cyc(0, 0, 1, 0, 12'h000, 12'h999);
    chk("wrap 001", dig_w, 12'h001);
    chk("wrap pulse end", c_W'(tr_w), '0);

    // Programmable limit and saturate
    cyc(0, 1, 0, 0, 12'h057, 12'h059);
    cyc(0, 0, 1, 0, 12'h000, 12'h059);
    cyc(0, 0, 1, 0, 12'h000, 12'h059);
    chk("sat 059", dig_s, 12'h059);
    chk("sat fim", c_W'(fim_s), c_W'(1));
    cyc(0, 0, 1, 0, 12'h000, 12'h059);
    chk("sat hold", dig_s, 12'h059);
    chk("sat pulse 1", c_W'(tr_s), c_W'(1));
    cyc(0, 0, 1, 0, 12'h000, 12'h059);
    chk("sat hold 2", dig_s, 12'h059);
    chk("sat pulse 2", c_W'(tr_s), c_W'(1));

    // Down-count borrow and wrap
    cyc(0, 1, 0, 1, 12'h101, 12'h120);
    cyc(0, 0, 1, 1, 12'h000, 12'h120);
    chk("down 100", dig_w, 12'h100);
    cyc(0, 0, 1, 1, 12'h000, 12'h120);
    chk("down 099", dig_w, 12'h099);
    cyc(0, 0, 1, 1, 12'h000, 12'h120);
    chk("down 098", dig_w, 12'h098);
    cyc(0, 1, 0, 1, 12'h000, 12'h120);
    chk("down fim at 000", c_W'(fim_w), c_W'(1));
    cyc(0, 0, 1, 1, 12'h000, 12'h120);
    chk("down wrap 120", dig_w, 12'h120);
    chk("down wrap pulse", c_W'(tr_w), c_W'(1));

    // Load sanitising and above-limit
    cyc(0, 1, 0, 0, 12'h1A3, 12'h0F5);
    chk("load clamp", dig_w, 12'h193);
    cyc(0, 0, 1, 0, 12'h000, 12'h0F5);
    chk("above limit wrap", dig_w, 12'h000);
    chk("above limit pulse", c_W'(tr_w), c_W'(1));
    chk("above limit sat", dig_s, 12'h193);

    // Priority
    cyc(1, 1, 1, 0, 12'h555, 12'h999);
    chk("prio clear", dig_w, 12'h000);
    chk("prio clear pulse", c_W'(tr_w), '0);
    cyc(0, 1, 1, 0, 12'h555, 12'h999);
    chk("prio load", dig_w, 12'h555);

    // Randomised traffic, checked by the per-cycle model compare
    for (int n = 0; n < 3000; n++) begin
      logic [c_W-1:0] v, l;
      v = c_W'($urandom);
      l = ($urandom_range(0, 3) == 0) ? c_W'($urandom_range(0, 15)) : c_W'($urandom);
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1, v, l);
    end

    @(posedge clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/contador_bcd_ndigitos.md
Name: contador_bcd_ndigitos

Overview:
- Parametrised synchronous BCD counter with DIGITS decimal digits.
- Adds the following to plain count-up-with-clear: up/down counting, parallel load, a programmable terminal value (limite), a wrap-or-saturate mode, and a registered overflow pulse.
- Used as the generic timer/score/event counter in datapaths (move timers, attempt counters, etc.).
- Digits are packed, with digit 0 (units) in the LSBs.

Parameters:
- DIGITS, 3, number of BCD digits (1..8); total data width is 4*DIGITS.
- WRAP, 1, 1 = wrap around at the boundaries; 0 = saturate (hold) at the boundaries.

Ports:
- clock  input  1  single system clock; all state updates on its rising edge.
- zera  input  1  synchronous active-high reset/clear; highest priority.
- conta  input  1  count enable; one step per cycle while high.
- decrementa  input  1  direction: 0 = count up, 1 = count down; sampled with conta.
- carrega  input  1  synchronous parallel load of valor_carga.
- valor_carga  input  4*DIGITS  BCD value to load.
- limite  input  4*DIGITS  BCD terminal value for up-count (inclusive maximum); wrap target for down-count.
- digitos  output  4*DIGITS  current count, BCD, registered.
- fim  output  1  combinational terminal flag.
- transbordo  output  1  registered one-cycle pulse on wrap or saturation event.

Behaviour:
- Clock and reset: one clock domain (clock). Reset is synchronous and active-high on zera.
- Reset values: digitos = 0 (all digits 4'd0), transbordo = 0.
- Priority per rising edge: zera > carrega > conta. When none is active, the state holds and transbordo = 0.
- Load: digitos <= valor_carga, with each input digit > 9 clamped to 9. transbordo = 0.
- limite sanitisation: any limite digit > 9 is treated as 9 (combinational clamp before every compare).
- Up-count step (conta=1, decrementa=0):
  - If digitos >= limite (numeric BCD compare; covers a loaded value above limite): WRAP=1 sets digitos <= 0; WRAP=0 holds. transbordo <= 1 next cycle in both modes.
  - Otherwise: ripple BCD increment. A digit at 9 becomes 0 and carries into the next digit. No binary values 10..15 ever appear.
- Down-count step (conta=1, decrementa=1):
  - If digitos == 0: WRAP=1 sets digitos <= limite (sanitised); WRAP=0 holds at 0. transbordo <= 1.
  - Otherwise: ripple BCD decrement. A digit at 0 becomes 9 and borrows from the next digit.
  - A value above limite decrements normally (no clamp).
- fim (combinational):
  - decrementa=0: fim = (digitos == limite).
  - decrementa=1: fim = (digitos == 0).
  - fim is independent of conta.
- transbordo: registered. High for exactly the one cycle after an edge that hit a boundary, then low unless the next edge also hits one. With WRAP=0 held at a boundary and conta held high, transbordo stays high every cycle.
- Latency: every update is visible on digitos one cycle after the edge. There is no pipeline.
- limite changing mid-count takes effect on the next compare; no state is stored from limite.
- zera asserted mid-count together with carrega or conta: clear wins, transbordo = 0.
- limite = 0 with up-count: every step is a boundary (WRAP=1 holds at 0 with transbordo high every cycle).

Decomposition:
- Shared header bcd_defs.vh: BCD_ZERO = 4'd0, BCD_MAX = 4'd9, macro/function for clamping a digit to 9.
- Sub-module digito_bcd: one digit register plus combinational next value.
  - Inputs: en, dir, cin/bin.
  - Outputs: value, cout/bout.
  - Instantiated DIGITS times in a generate loop with a ripple chain.
  - Load, clear and boundary override are driven from the top level.
- Top level holds: the sanitised-limite compare (magnitude compare MS-digit first), the boundary decision, and the transbordo register.

Test Plan (DIGITS=3):
- Reset and basic up-count: zera 1 cycle, then conta=1 for 12 cycles with limite=999, WRAP=1 -> digitos 000 then 001..012; ripple 009->010 is correct; fim=0, transbordo=0 throughout.
- Full-range wrap: load 998, limite=999, count up 2 -> 999 (fim=1), then 000 with transbordo=1 for exactly one cycle, then 001 with transbordo=0.
- Programmable limit and saturate: WRAP=0, limite=059, load 057, count up 4 -> 058, 059 (fim=1), 059, 059; transbordo=1 on the last two cycles.
- Down-count borrow and wrap: WRAP=1, limite=120, load 101, decrementa=1, count 3 -> 100, 099, 098. Then load 000 and count 1 -> 120 with transbordo=1. fim=1 while 000 with decrementa=1.
- Load sanitising and above-limit: limite=0F5 (reads 095), load 1A3 -> digitos 193; count up 1 -> 000 with transbordo=1 (193 >= 095).
- Priority: zera=carrega=conta=1 with valor_carga=555 -> 000. Then carrega=conta=1 -> 555 (load wins, no increment).
